// File: rtl/sram_capture_ctrl.sv
// Capture/readout controller for the 512x8 sample RAM.
// Fills one block from the CIC stream, then streams it back out in order.
module sram_capture_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  busy,
    output logic                  done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        FLUSH,
        READ_REQ,
        READ_WAIT,
        OUTPUT
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH:0]   wr_ptr, wr_ptr_n;
    logic [ADDR_WIDTH:0]   rd_ptr, rd_ptr_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] din_n;
    logic                  we_n;
    logic [DATA_WIDTH-1:0] m_data_n;
    logic                  m_valid_n;
    logic                  done_n;

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_n   = state;
        wr_ptr_n  = wr_ptr;
        rd_ptr_n  = rd_ptr;
        addr_n    = ram_addr;
        din_n     = ram_din;
        we_n      = ram_we;
        m_data_n  = m_data;
        m_valid_n = m_valid;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    wr_ptr_n = '0;
                    state_n  = CAPTURE;
                end
            end
            CAPTURE: begin
                if (s_valid) begin
                    we_n     = 1'b1;
                    din_n    = s_data;
                    addr_n   = wr_ptr[ADDR_WIDTH-1:0];
                    wr_ptr_n = wr_ptr + 1'b1;
                    if (wr_ptr == LAST) begin
                        state_n = FLUSH;
                    end
                end else begin
                    we_n = 1'b0;
                end
            end
            FLUSH: begin
                we_n     = 1'b0;
                addr_n   = '0;
                rd_ptr_n = '0;
                state_n  = READ_REQ;
            end
            READ_REQ: begin
                state_n = READ_WAIT;
            end
            READ_WAIT: begin
                m_data_n  = ram_dout;
                m_valid_n = 1'b1;
                state_n   = OUTPUT;
            end
            OUTPUT: begin
                if (m_ready) begin
                    m_valid_n = 1'b0;
                    if (rd_ptr == LAST) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        rd_ptr_n = rd_ptr + 1'b1;
                        addr_n   = rd_ptr_n[ADDR_WIDTH-1:0];
                        state_n  = READ_REQ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, pointers and all outputs registered; synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            ram_addr <= addr_n;
            ram_din  <= din_n;
            ram_we   <= we_n;
            m_data   <= m_data_n;
            m_valid  <= m_valid_n;
            busy     <= (state_n != IDLE);
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_sram_capture_ctrl.sv
// Bench for sram_capture_ctrl with a behavioural 512x8 RAM.
// Scoreboard queue plus table-driven reset/capture vectors.
module tb_sram_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [8:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_we;
    logic [7:0] ram_dout;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int rdy_mode = 0;
    logic [7:0] sb[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] mem [512];

    sram_capture_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_data(s_data), .s_valid(s_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Read-first synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dgen(input int kind, input int i);
        case (kind)
            0: return 8'(i);
            1: return 8'hA5 ^ 8'(i);
            2: return 8'(i * 7 + 3);
            3: return 8'hFF;
            default: return 8'h5A ^ 8'(i);
        endcase
    endfunction

    // Consumer ready pattern: always, ~30% random, or never.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: m_ready = ($urandom_range(0, 99) < 30);
            default: m_ready = 1'b0;
        endcase
    end

    // Output monitor: scoreboard pops, stability, write and done counts.
    always @(negedge clk) begin
        if (rst_n && prev_hold) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                chk("m_data", 32'(m_data), 32'(sb.pop_front()));
            end
        end
        prev_hold = rst_n && m_valid && !m_ready;
        prev_data = m_data;
        if (ram_we) we_cnt++;
        if (done) done_cnt++;
    end

    task automatic capture(input int kind, input int gap,
                           input bit noisy, input int n);
        start = 1'b1;
        step();
        start = 1'b0;
        we_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = dgen(kind, i);
            start   = noisy && (i % 50 == 7);
            sb.push_back(s_data);
            step();
            s_valid = 1'b0;
            start   = 1'b0;
            if (i < n - 1) repeat (gap) step();
        end
        if (n == 512) begin
            step();
            chk("lat_e1", 32'(m_valid), 32'd0);
            step();
            chk("lat_e2", 32'(m_valid), 32'd0);
            step();
            chk("lat_e3", 32'(m_valid), 32'd1);
            chk("busy_rd", 32'(busy), 32'd1);
        end
    endtask

    task automatic finish_block(input bit noisy);
        bit got = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (noisy) begin
                s_valid = (c % 7 < 3);
                s_data  = 8'hEE;
                start   = (c % 40 == 11);
            end
            step();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        step();
        chk("done_1cyc", 32'(done), 32'd0);
        chk("done_cnt", 32'(done_cnt), 32'd1);
        chk("we_cnt", 32'(we_cnt), 32'd512);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       s_valid;
        logic [7:0] s_data;
        logic       busy;
        logic       we;
        logic [8:0] addr;
        logic [7:0] din;
    } vec_t;

    vec_t tv[9];

    initial begin
        #200_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 8'h00};
        tv[1] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 9'd0, 8'h00};
        tv[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 9'd0, 8'h00};
        tv[3] = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 9'd0, 8'h11};
        tv[4] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 9'd1, 8'h22};
        tv[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'd1, 8'h22};
        tv[6] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 9'd2, 8'h33};
        tv[7] = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 9'd0, 8'h00};
        tv[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 8'h00};

        step();
        for (int k = 0; k < 9; k++) begin
            rst_n   = tv[k].rst_n;
            start   = tv[k].start;
            s_valid = tv[k].s_valid;
            s_data  = tv[k].s_data;
            step();
            chk($sformatf("tv%0d_busy", k), 32'(busy), 32'(tv[k].busy));
            chk($sformatf("tv%0d_we", k), 32'(ram_we), 32'(tv[k].we));
            chk($sformatf("tv%0d_addr", k), 32'(ram_addr), 32'(tv[k].addr));
            chk($sformatf("tv%0d_din", k), 32'(ram_din), 32'(tv[k].din));
            chk($sformatf("tv%0d_mv", k), 32'(m_valid), 32'd0);
            chk($sformatf("tv%0d_done", k), 32'(done), 32'd0);
        end
        start   = 1'b0;
        s_valid = 1'b0;
        sb.delete();

        rdy_mode = 0;
        capture(0, 0, 1'b0, 512);
        finish_block(1'b0);

        capture(1, 4, 1'b0, 512);
        finish_block(1'b0);

        rdy_mode = 1;
        capture(2, 0, 1'b0, 512);
        finish_block(1'b0);

        capture(4, 1, 1'b1, 512);
        finish_block(1'b1);

        rdy_mode = 0;
        capture(0, 0, 1'b0, 100);
        rst_n = 1'b0;
        sb.delete();
        repeat (2) begin
            step();
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_we", 32'(ram_we), 32'd0);
            chk("rst_addr", 32'(ram_addr), 32'd0);
            chk("rst_din", 32'(ram_din), 32'd0);
            chk("rst_mv", 32'(m_valid), 32'd0);
            chk("rst_mdata", 32'(m_data), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        step();
        capture(3, 0, 1'b0, 512);
        finish_block(1'b0);

        rdy_mode = 2;
        capture(0, 0, 1'b0, 512);
        repeat (3) step();
        chk("stall_mv", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'd0);
        rst_n = 1'b0;
        sb.delete();
        step();
        chk("rrd_mv", 32'(m_valid), 32'd0);
        chk("rrd_busy", 32'(busy), 32'd0);
        chk("rrd_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (4) step();
        chk("rrd_nodone", 32'(done_cnt), 32'd0);
        chk("rrd_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
